// File: rtl/inst_stream_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : inst_stream_encoder
//  Description : Packs decoded RV32I instruction descriptors (opcode, register
//                fields, funct fields, full 32-bit immediate) into 32-bit
//                instruction words and writes them sequentially into
//                instruction memory over a valid/ready write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_stream_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        err_imm,
    output logic        err_full,
    output logic        done,
    output logic [15:0] inst_count
);

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    // Count width is 16 bits; one extra bit keeps the compare exact.
    localparam logic [16:0] DEPTH_CMP = 17'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_imm_q, err_imm_d;
    logic        err_full_q, err_full_d;
    logic [15:0] count_q, count_d;
    logic        last_q, last_d;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        imm_fits_12;   // imm[31:11] is a pure sign extension
    logic        imm_fits_13;   // imm[31:12] is a pure sign extension
    logic        imm_fits_21;   // imm[31:20] is a pure sign extension
    logic [16:0] count_inc;

    assign imm_fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign imm_fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign count_inc   = {1'b0, count_q} + 17'd1;

    // Scatter the immediate into the format selected by the opcode and flag
    // out-of-range, misaligned or unknown encodings (word still produced).
    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b0;
        case (in_opcode)
            OP_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = ~imm_fits_12;
            end
            OP_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad  = ~imm_fits_12;
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_bad  = ~imm_fits_13 | in_imm[0];
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_bad  = ~imm_fits_21 | in_imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = |in_imm[11:0];
            end
            default: begin
                enc_word = NOP_WORD;
                enc_bad  = 1'b1;
            end
        endcase
    end

    // Next-state and handshake decode: accept in IDLE, write in WRITE,
    // park in DONE until a start pulse rearms the block.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_imm_d  = err_imm_q;
        err_full_d = err_full_q;
        count_d    = count_q;
        last_d     = last_q;
        in_ready   = 1'b0;
        mem_write  = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wdata_d = enc_word;
                    last_d  = in_last;
                    if (enc_bad) begin
                        err_imm_d = 1'b1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    count_d = count_inc[15:0];
                    addr_d  = addr_q + 32'd4;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (count_inc == DEPTH_CMP) begin
                        err_full_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    addr_d     = BASE_ADDR;
                    count_d    = 16'd0;
                    err_imm_d  = 1'b0;
                    err_full_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
            err_imm_q  <= 1'b0;
            err_full_q <= 1'b0;
            count_q    <= 16'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_imm_q  <= err_imm_d;
            err_full_q <= err_full_d;
            count_q    <= count_d;
            last_q     <= last_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign err_imm    = err_imm_q;
    assign err_full   = err_full_q;
    assign inst_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_stream_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_inst_stream_encoder
//  Description : Self-checking bench for inst_stream_encoder. Directed program
//                fragments plus randomized programs; expected writes queued at
//                issue and matched by an independent write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_stream_encoder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        err_imm;
    logic        err_full;
    logic        done;
    logic [15:0] inst_count;

    inst_stream_encoder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .err_imm    (err_imm),
        .err_full   (err_full),
        .done       (done),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Program-level reference state
    logic [31:0] m_addr = BASE;
    int          m_count = 0;
    bit          m_err_imm = 1'b0;
    bit          m_err_full = 1'b0;
    bit          m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: positions computed with shifts/masks, legality from
    // signed numeric ranges and alignment.
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm,
                                       output logic [31:0] word, output bit bad);
        longint s;
        logic [31:0] base_fields;
        s = longint'($signed(imm));
        base_fields = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        bad = 1'b0;
        case (op)
            7'b0110011: word = (32'(f7) << 25) | base_fields | (32'(rd) << 7) | 32'(op);
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                word = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                       | (32'(rd) << 7) | 32'(op);
                bad  = (s < -2048) || (s > 2047);
            end
            7'b0100011: begin
                word = (((imm >> 5) & 32'h7F) << 25) | base_fields
                       | ((imm & 32'h1F) << 7) | 32'(op);
                bad  = (s < -2048) || (s > 2047);
            end
            7'b1100011: begin
                word = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                       | base_fields | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 32'h1) << 7) | 32'(op);
                bad  = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            7'b1101111: begin
                word = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                       | (32'(rd) << 7) | 32'(op);
                bad  = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            end
            7'b0110111, 7'b0010111: begin
                word = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                bad  = (imm % 4096 != 0);
            end
            default: begin
                word = 32'h0000_0013;
                bad  = 1'b1;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_addr = BASE; m_count = 0; m_err_imm = 1'b0; m_err_full = 1'b0; m_done = 1'b0;
    endtask

    // Issue one descriptor, optionally stall the memory side, then commit.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit last, input logic [31:0] exp_word,
                        input int stall, input bit noisy);
        logic [31:0] mw;
        bit bad;
        bit committed;
        int n;
        exp_t e;
        ref_encode(op, rd, rs1, rs2, f3, f7, imm, mw, bad);
        if (noisy && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        e.addr = m_addr;
        e.data = exp_word;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            chk("stall_mem_write", 32'(mem_write), 32'd1);
            chk("stall_mem_addr", mem_addr, e.addr);
            chk("stall_mem_wdata", mem_wdata, e.data);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        n = 0;
        do begin
            mem_ready = (noisy && n < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noisy) begin
                start     = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_opcode = 7'($urandom);
                in_imm    = $urandom;
            end
            committed = mem_ready;
            @(posedge clk); #1;
            n++;
        end while (!committed);
        mem_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
        m_count++;
        m_addr = m_addr + 32'd4;
        if (bad) m_err_imm = 1'b1;
        if (last) begin
            m_done = 1'b1;
        end else if (m_count == DEPTH) begin
            m_err_full = 1'b1;
            m_done = 1'b1;
        end
        chk("inst_count", 32'(inst_count), 32'(m_count));
        chk("err_imm", 32'(err_imm), 32'(m_err_imm));
        chk("err_full", 32'(err_full), 32'(m_err_full));
        chk("done", 32'(done), 32'(m_done));
        chk("in_ready_after", 32'(in_ready), 32'(!m_done));
    endtask

    // Descriptors offered while DONE must not be taken.
    task automatic poke_while_done();
        in_opcode = 7'b0010011; in_imm = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_mem_write", 32'(mem_write), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic restart(input bit with_valid);
        chk("pre_start_done", 32'(done), 32'd1);
        in_opcode = 7'b0010011; in_imm = 32'd3;
        in_valid = with_valid;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        model_reset();
        chk("start_done", 32'(done), 32'd0);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_mem_addr", mem_addr, BASE);
        chk("start_count", 32'(inst_count), 32'd0);
        chk("start_err_imm", 32'(err_imm), 32'd0);
        chk("start_err_full", 32'(err_full), 32'd0);
        @(posedge clk); #1;
        chk("start_no_accept", 32'(mem_write), 32'd0);
    endtask

    task automatic rand_program();
        logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
        int len;
        logic [6:0] op;
        logic [31:0] imm, w;
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        bit bad;
        len = $urandom_range(1, 11);
        for (int k = 0; k < len && !m_done; k++) begin
            int idx;
            idx = $urandom_range(0, 10);
            op = (idx == 10) ? 7'($urandom) : ops[idx];
            t12 = 12'($urandom); t13 = 13'($urandom); t21 = 21'($urandom);
            case ($urandom_range(0, 4))
                0: imm = $urandom;
                1: imm = {{20{t12[11]}}, t12};
                2: imm = {{19{t13[12]}}, t13[12:1], 1'b0};
                3: imm = {{11{t21[20]}}, t21[20:1], 1'b0};
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
            in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
            ref_encode(op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, imm, w, bad);
            send(op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, imm, k == len - 1, w,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0, 1'b1);
        end
        poke_while_done();
        restart(1'($urandom_range(0, 1)));
    endtask

    // Monitor: every accepted memory write is matched against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_write && mem_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h@%h expected=none at %0t",
                             mem_wdata, mem_addr, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bit bad;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_err_imm", 32'(err_imm), 32'd0);
        chk("rst_err_full", 32'(err_full), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(inst_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // addi / sw / beq / jal program
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093, 0, 1'b0);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 0, 1'b0);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3, 0, 1'b0);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0080_00EF, 0, 1'b0);
        poke_while_done();
        restart(1'b1);

        // sticky immediate errors, plus a 3-cycle memory stall
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0, 32'h8000_0093, 0, 1'b0);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0, 32'h0000_0363, 0, 1'b0);
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0113, 3, 1'b0);
        send(7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_51B7, 0, 1'b0);
        restart(1'b0);

        // overflow: DEPTH words without in_last
        for (int k = 0; k < DEPTH; k++) begin
            ref_encode(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), w, bad);
            send(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, w, 0, 1'b0);
        end
        poke_while_done();
        restart(1'b1);

        for (int p = 0; p < 25; p++) begin
            rand_program();
        end

        // asynchronous reset in the middle of a stalled write
        send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0, 32'h0040_0213, 0, 1'b0);
        in_opcode = 7'b0010011; in_rd = 5'd5; in_imm = 32'd7; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mem_ready = 1'b0;
        chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        chk("arst_mem_write", 32'(mem_write), 32'd0);
        chk("arst_mem_addr", mem_addr, BASE);
        chk("arst_mem_wdata", mem_wdata, 32'd0);
        chk("arst_count", 32'(inst_count), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b1, 32'h0090_0313, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
